// File: rtl/mult_share_arb_if.sv
// Operand, shared-multiplier and result signals of the mult_share_arb block.
// master: the arbiter side; slave: the requesters, multiplier and consumer side.
interface mult_share_arb_if #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int NREQ = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*M-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [M-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [M+N-1:0]    mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [M+N-1:0]    rsp_product;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_product, rsp_id, busy
  );

  modport slave (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_product, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin share of one combinational multiplier; accept->rsp_valid visible after 2 edges.
// Backpressure: response held until rsp_ready; no request is accepted until it is taken.
module mult_share_arb #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int NREQ = 2
) (
  input logic              clk,
  input logic              rst_n,
  mult_share_arb_if.master bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    rr_ptr, gnt_id, gnt_off, id_q;
  logic              gnt_vld, accept, rsp_take;
  logic [2*NREQ-1:0] vld_dbl;
  logic [NREQ-1:0]   vld_rot, req_ready_c;
  logic [IDW:0]      gnt_sum;
  logic [M-1:0]      a_sel, mul_a_q;
  logic [N-1:0]      b_sel, mul_b_q;
  logic [M+N-1:0]    prod_q;
  logic              rsp_vld_q;

  // Rotate the valids so bit 0 is the requester at rr_ptr; first set bit wins.
  assign vld_dbl = {bus.req_valid, bus.req_valid};
  assign vld_rot = vld_dbl[rr_ptr +: NREQ];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        gnt_vld = 1'b1;
        gnt_off = IDW'(i);
      end
    end
  end

  assign gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
  assign gnt_id  = (gnt_sum >= NREQ_W) ? IDW'(gnt_sum - NREQ_W) : gnt_sum[IDW-1:0];

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        a_sel = bus.req_a[i*M +: M];
        b_sel = bus.req_b[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign rsp_take = rsp_vld_q & bus.rsp_ready;

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld && rst_n) begin
          req_ready_c = NREQ'(1) << gnt_id;
          accept      = 1'b1;
          state_nxt   = CALC;
        end
      end
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      prod_q    <= '0;
      id_q      <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        mul_a_q <= a_sel;
        mul_b_q <= b_sel;
        id_q    <= gnt_id;
        rr_ptr  <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end
      if (state == CALC) begin
        prod_q    <= bus.mul_p;
        rsp_vld_q <= 1'b1;
      end else if (rsp_take) begin
        rsp_vld_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.rsp_valid   = rsp_vld_q;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_id      = id_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios then random traffic against a
// transaction-level model (grant order, response timing, expected product).
module tb_mult_share_arb;
  localparam int M    = 4;
  localparam int N    = 4;
  localparam int NREQ = 2;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mult_share_arb_if #(.M(M), .N(N), .NREQ(NREQ)) bus ();

  mult_share_arb #(.M(M), .N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the shared mult_mnbit.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: outstanding operation, edge it was accepted on, round-robin pointer.
  int         m_rr       = 0;
  bit         m_out      = 1'b0;
  int         m_acc_edge = 0;
  bit         m_rst_edge = 1'b1;
  int         edge_cnt   = 0;
  logic [3:0] m_a, m_b;
  logic [7:0] m_prod;
  int         m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int grant_of(input logic [NREQ-1:0] v, input int rr);
    int k;
    for (int i = 0; i < NREQ; i++) begin
      k = (rr + i) % NREQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1, input logic rdy);
    bus.req_valid = v;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.rsp_ready = rdy;
  endtask

  // Called just after a falling edge with inputs driven; checks, then crosses one rising edge.
  task automatic step();
    int         g;
    logic [1:0] exp_rdy;
    bit         exp_rv;
    #1;
    g       = (rst_n && !m_out) ? grant_of(bus.req_valid, m_rr) : -1;
    exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
    // The consumer can first take a response on the second edge after the accept.
    exp_rv  = m_out && (edge_cnt + 1 >= m_acc_edge + 2);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    chk("busy", 32'(bus.busy), 32'(m_out));
    if (exp_rv) begin
      chk("rsp_product", 32'(bus.rsp_product), 32'(m_prod));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
    end
    if (m_out) begin
      chk("mul_a", 32'(bus.mul_a), 32'(m_a));
      chk("mul_b", 32'(bus.mul_b), 32'(m_b));
    end else if (m_rst_edge) begin
      chk("rst_mul_a", 32'(bus.mul_a), 32'd0);
      chk("rst_mul_b", 32'(bus.mul_b), 32'd0);
      chk("rst_product", 32'(bus.rsp_product), 32'd0);
      chk("rst_id", 32'(bus.rsp_id), 32'd0);
    end
    @(posedge clk);
    edge_cnt++;
    if (!rst_n) begin
      m_out      = 1'b0;
      m_rr       = 0;
      m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      if (exp_rv && bus.rsp_ready) begin
        m_out = 1'b0;
      end else if (g >= 0) begin
        m_out      = 1'b1;
        m_acc_edge = edge_cnt;
        m_a        = bus.req_a[g*M +: M];
        m_b        = bus.req_b[g*N +: N];
        m_prod     = 8'(m_a) * 8'(m_b);
        m_id       = g;
        m_rr       = (g + 1) % NREQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // 1: reset held with every requester valid
    rst_n = 1'b0;
    drive(2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // 2: single requester, largest operands
    drive(2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b1);
    step();
    drive(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step();
    chk("t2_product", 32'(bus.rsp_product), 32'd225);
    chk("t2_id", 32'(bus.rsp_id), 32'd0);
    step();

    // 3: both held valid from a fresh pointer -> id0, id1, id0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(2'b11, 4'd3, 4'd5, 4'd7, 4'd9, 1'b1);
    step(); step();
    chk("t3_first_product", 32'(bus.rsp_product), 32'd15);
    chk("t3_first_id", 32'(bus.rsp_id), 32'd0);
    step(); step(); step();
    chk("t3_second_product", 32'(bus.rsp_product), 32'd63);
    chk("t3_second_id", 32'(bus.rsp_id), 32'd1);
    step(); step(); step();
    chk("t3_third_id", 32'(bus.rsp_id), 32'd0);
    step();

    // 4: consumer stalls for 5 cycles while the other requester waits
    drive(2'b10, 4'd0, 4'd0, 4'd5, 4'd6, 1'b0);
    step(); step();
    drive(2'b11, 4'd9, 4'd9, 4'd5, 4'd6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_product", 32'(bus.rsp_product), 32'd30);
      chk("t4_hold_id", 32'(bus.rsp_id), 32'd1);
      step();
    end
    drive(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step();
    step();

    // 5: zero operands and pointer wrap back to requester 0
    drive(2'b01, 4'd0, 4'd13, 4'd0, 4'd0, 1'b1);
    step(); step();
    chk("t5_zero_a", 32'(bus.rsp_product), 32'd0);
    step();
    drive(2'b10, 4'd0, 4'd0, 4'd15, 4'd0, 1'b1);
    step(); step();
    chk("t5_zero_b", 32'(bus.rsp_product), 32'd0);
    step();
    drive(2'b11, 4'd2, 4'd2, 4'd3, 4'd3, 1'b1);
    #1;
    chk("t5_wrap_grant", 32'(bus.req_ready), 32'd1);
    step(); step(); step();

    // 6: reset while the multiply is in flight
    drive(2'b01, 4'd2, 4'd3, 4'd0, 4'd0, 1'b1);
    step();
    rst_n = 1'b0;
    drive(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step();
    rst_n = 1'b1;
    drive(2'b11, 4'd4, 4'd4, 4'd6, 4'd6, 1'b1);
    #1;
    chk("t6_grant_after_reset", 32'(bus.req_ready), 32'd1);
    step(); step(); step(); step();

    // Random traffic: changing operands, dropped valids, stalls, rare resets.
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;
    drive(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
